// File: rtl/mux_arb_n_pkg.sv
// -----------------------------------------------------------------------------
// mux_arb_n_pkg
//   Shared definitions for the registered N-input selector/arbiter.
//   - MODE_SEL / MODE_RR : encodings of the 'mode' input
//   - wrap_inc()         : modulo-N increment of a channel index, done with an
//                          explicit compare so that N need not be a power of 2
// -----------------------------------------------------------------------------
package mux_arb_n_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mux_arb_n_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter_n
//   Round-robin request picker. Holds the pointer to the last granted channel
//   and searches rr_ptr+1, rr_ptr+2, ... (mod NUM_IN) for the first request.
// Ports
//   Clk      in   rising-edge clock
//   Rst_n    in   asynchronous active-low reset (rr_ptr -> NUM_IN-1)
//   req      in   NUM_IN request vector
//   advance  in   the grant is being taken this cycle; move rr_ptr to it
//   gnt_idx  out  index of the selected request (valid when gnt_vld)
//   gnt_vld  out  at least one request is present
// -----------------------------------------------------------------------------
module rr_arbiter_n
    import mux_arb_n_pkg::*;
#(
    parameter int NUM_IN = 6,
    parameter int SEL_W  = 3
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [NUM_IN-1:0] req,
    input  logic              advance,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              gnt_vld
);

    logic [SEL_W-1:0] rr_ptr;

    // The search starts one past the pointer so that the last winner has the
    // lowest priority next time; the reset value NUM_IN-1 makes ch0 first.
    always_comb begin
        int cand;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = int'(rr_ptr);
        for (int i = 0; i < NUM_IN; i++) begin
            cand = wrap_inc(cand, NUM_IN);
            if (!gnt_vld && req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = SEL_W'(cand);
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rr_ptr <= SEL_W'(NUM_IN - 1);
        end else if (advance && gnt_vld) begin
            rr_ptr <= gnt_idx;
        end
    end

endmodule

// File: rtl/mux_arb_n.sv
// -----------------------------------------------------------------------------
// mux_arb_n
//   N-input, WIDTH-bit registered selector for a shared result bus.
//   mode=0 : explicit select, 'sel' picks the source channel
//   mode=1 : round-robin over the valid channels
//   One output register stage with valid/ready; full throughput.
// Ports
//   Clk, Rst_n  clock, asynchronous active-low reset
//   in_data     NUM_IN*WIDTH, channel k at [k*WIDTH +: WIDTH]
//   in_valid    per-channel data present
//   in_ready    per-channel transfer this cycle (combinational, one-hot or 0)
//   mode, sel   source selection controls
//   out_data    registered data, out_valid / out_ready handshake
//   out_src     channel index that produced out_data
//   sel_err     1-cycle pulse after a load cycle with sel >= NUM_IN in select mode
// -----------------------------------------------------------------------------
module mux_arb_n
    import mux_arb_n_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 6,
    parameter int SEL_W  = 3
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_src,
    output logic                    sel_err
);

    localparam int PAD_N = 1 << SEL_W;

    logic [WIDTH-1:0] data_p1;
    logic [SEL_W-1:0] src_p1;
    logic             vld_p1;
    logic             err_p1;

    logic             load;
    logic             sel_ok;
    logic [PAD_N-1:0] valid_pad;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_vld;
    logic [SEL_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic [WIDTH-1:0] gnt_data;
    logic             err_nxt;

    // ---- stage p0: grant decision (combinational) ----
    assign load   = ~vld_p1 | out_ready;
    assign sel_ok = (int'(sel) < NUM_IN);

    // Zero-padded copy so that any sel value indexes a real bit.
    always_comb begin
        valid_pad               = '0;
        valid_pad[NUM_IN-1:0]   = in_valid;
    end

    rr_arbiter_n #(
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_rr (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .req     (in_valid),
        .advance (load && (mode == MODE_RR)),
        .gnt_idx (rr_idx),
        .gnt_vld (rr_vld)
    );

    always_comb begin
        if (mode == MODE_RR) begin
            gnt_idx = rr_idx;
            gnt_vld = load & rr_vld;
        end else begin
            gnt_idx = sel;
            gnt_vld = load & sel_ok & valid_pad[sel];
        end
    end

    assign err_nxt = (mode == MODE_SEL) & load & ~sel_ok;

    always_comb begin
        gnt_data = '0;
        in_ready = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (gnt_idx == SEL_W'(k)) begin
                gnt_data    = in_data[k*WIDTH +: WIDTH];
                in_ready[k] = gnt_vld;
            end
        end
    end

    // ---- stage p1: output register ----
    // A held word is only replaced on a grant; a load cycle without a grant
    // just drops valid and leaves data/src as they were.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            data_p1 <= '0;
            src_p1  <= '0;
            vld_p1  <= 1'b0;
            err_p1  <= 1'b0;
        end else begin
            err_p1 <= err_nxt;
            if (gnt_vld) begin
                data_p1 <= gnt_data;
                src_p1  <= gnt_idx;
                vld_p1  <= 1'b1;
            end else if (load) begin
                vld_p1  <= 1'b0;
            end
        end
    end

    assign out_data  = data_p1;
    assign out_src   = src_p1;
    assign out_valid = vld_p1;
    assign sel_err   = err_p1;

endmodule
